// File: rtl/deco_lectura_rtc_pkg.sv
// Shared definitions for the RTC read-direction decoder.
//   estado_t   : 2-bit FSM state encoding
//   OFS_*      : field offsets relative to the seconds register address
//   MIN_*/MAX_*: legal binary range of each time field
//   en_rango   : checks a converted value against the range of its field
package rtc_lectura_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ESPERA_DATO = 2'd1,
    CONVERTIR   = 2'd2,
    PUBLICAR    = 2'd3
  } estado_t;

  localparam int NUM_CAMPOS = 6;

  localparam logic [2:0] OFS_SEG   = 3'd0;
  localparam logic [2:0] OFS_MIN   = 3'd1;
  localparam logic [2:0] OFS_HORA  = 3'd2;
  localparam logic [2:0] OFS_FECHA = 3'd3;
  localparam logic [2:0] OFS_MES   = 3'd4;
  localparam logic [2:0] OFS_ANIO  = 3'd5;

  localparam logic [6:0] MIN_SEG   = 7'd0;
  localparam logic [6:0] MAX_SEG   = 7'd59;
  localparam logic [6:0] MIN_MIN   = 7'd0;
  localparam logic [6:0] MAX_MIN   = 7'd59;
  localparam logic [6:0] MIN_HORA  = 7'd0;
  localparam logic [6:0] MAX_HORA  = 7'd23;
  localparam logic [6:0] MIN_FECHA = 7'd1;
  localparam logic [6:0] MAX_FECHA = 7'd31;
  localparam logic [6:0] MIN_MES   = 7'd1;
  localparam logic [6:0] MAX_MES   = 7'd12;
  localparam logic [6:0] MIN_ANIO  = 7'd0;
  localparam logic [6:0] MAX_ANIO  = 7'd99;

  // Offsets outside 0..5 get an empty range so they can never validate.
  function automatic logic en_rango(input logic [2:0] ofs, input logic [6:0] v);
    logic [6:0] lo;
    logic [6:0] hi;
    lo = 7'd1;
    hi = 7'd0;
    case (ofs)
      OFS_SEG:   begin lo = MIN_SEG;   hi = MAX_SEG;   end
      OFS_MIN:   begin lo = MIN_MIN;   hi = MAX_MIN;   end
      OFS_HORA:  begin lo = MIN_HORA;  hi = MAX_HORA;  end
      OFS_FECHA: begin lo = MIN_FECHA; hi = MAX_FECHA; end
      OFS_MES:   begin lo = MIN_MES;   hi = MAX_MES;   end
      OFS_ANIO:  begin lo = MIN_ANIO;  hi = MAX_ANIO;  end
      default:   begin lo = 7'd1;      hi = 7'd0;      end
    endcase
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/deco_lectura_rtc_if.sv
// Multiplexed RTC address/data bus as seen by the read decoder.
//   enable_leer : read transaction in progress
//   A_D         : 0 = address byte, 1 = data byte
//   strobe      : one-cycle pulse, dato_bus valid
//   dato_bus    : byte sampled from the RTC AD bus
// master drives the bus (bus controller / bench), slave samples it (decoder).
interface deco_lectura_rtc_if;
  logic       enable_leer;
  logic       A_D;
  logic       strobe;
  logic [7:0] dato_bus;

  modport master (output enable_leer, output A_D, output strobe, output dato_bus);
  modport slave  (input  enable_leer, input  A_D, input  strobe, input  dato_bus);
endinterface

// File: rtl/deco_lectura_rtc_bcd_a_bin.sv
// Combinational packed-BCD to binary converter.
//   bcd       : two BCD digits, tens in [7:4], units in [3:0]
//   bin       : tens*10 + units (meaningless when digito_ok is low)
//   digito_ok : both nibbles are decimal digits (<= 9)
module bcd_a_bin (
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       digito_ok
);

  logic [6:0] dec7;
  logic [6:0] uni7;

  assign dec7 = {3'b000, bcd[7:4]};
  assign uni7 = {3'b000, bcd[3:0]};

  // tens*10 as tens*8 + tens*2, avoiding a multiplier.
  assign bin       = (dec7 << 3) + (dec7 << 1) + uni7;
  assign digito_ok = (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);

endmodule

// File: rtl/deco_lectura_rtc.sv
// RTC read decoder: captures the register address and the returned BCD byte
// from the multiplexed bus, converts and range-checks it, and updates one of
// six binary time fields.
//   clk, rst_n   : clock, asynchronous active-low reset
//   bus          : read-side bus (slave modport)
//   segundos..anio : binary time shadow, N bits each
//   dato_listo   : one-cycle pulse, a field was written
//   error_bcd    : one-cycle pulse, data byte rejected
//   sobrecarga   : one-cycle pulse, strobe arrived while busy and was dropped
module deco_lectura_rtc
  import rtc_lectura_pkg::*;
#(
  parameter int         N        = 7,
  parameter logic [7:0] DIR_BASE = 8'h21
) (
  input  logic                 clk,
  input  logic                 rst_n,
  deco_lectura_rtc_if.slave    bus,
  output logic [N-1:0]         segundos,
  output logic [N-1:0]         minutos,
  output logic [N-1:0]         horas,
  output logic [N-1:0]         fecha,
  output logic [N-1:0]         mes,
  output logic [N-1:0]         anio,
  output logic                 dato_listo,
  output logic                 error_bcd,
  output logic                 sobrecarga
);

  estado_t    estado_q, estado_d;
  logic       ld_dir, ld_dato, ld_conv, publicar, sobre_d;
  logic [7:0] dir_p0, dato_p0;
  logic [7:0] desp;
  logic       en_mapa;
  logic [6:0] bin_c;
  logic       digito_ok;
  logic       valido_c;
  logic [6:0] bin_p1;
  logic [2:0] ofs_p1;
  logic       valido_p1;
  logic [N-1:0] campo [NUM_CAMPOS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado_q <= IDLE;
    else        estado_q <= estado_d;
  end

  always_comb begin
    estado_d = estado_q;
    ld_dir   = 1'b0;
    ld_dato  = 1'b0;
    ld_conv  = 1'b0;
    publicar = 1'b0;
    sobre_d  = 1'b0;
    case (estado_q)
      IDLE: begin
        if (bus.enable_leer && bus.strobe && !bus.A_D) begin
          ld_dir   = 1'b1;
          estado_d = ESPERA_DATO;
        end
      end
      ESPERA_DATO: begin
        // Losing enable_leer aborts even if a strobe shows up in the same cycle.
        if (!bus.enable_leer) begin
          estado_d = IDLE;
        end else if (bus.strobe && !bus.A_D) begin
          ld_dir = 1'b1;
        end else if (bus.strobe && bus.A_D) begin
          ld_dato  = 1'b1;
          estado_d = CONVERTIR;
        end
      end
      CONVERTIR: begin
        ld_conv  = 1'b1;
        sobre_d  = bus.strobe;
        estado_d = PUBLICAR;
      end
      PUBLICAR: begin
        publicar = 1'b1;
        sobre_d  = bus.strobe;
        estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // Stage p0: captured address and data bytes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_p0  <= '0;
      dato_p0 <= '0;
    end else begin
      if (ld_dir)  dir_p0  <= bus.dato_bus;
      if (ld_dato) dato_p0 <= bus.dato_bus;
    end
  end

  bcd_a_bin u_bcd_a_bin (
    .bcd       (dato_p0),
    .bin       (bin_c),
    .digito_ok (digito_ok)
  );

  assign desp     = dir_p0 - DIR_BASE;
  assign en_mapa  = (desp < 8'd6);
  assign valido_c = digito_ok && en_mapa && en_rango(desp[2:0], bin_c);

  // Stage p1: converted value, target field and verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_p1    <= '0;
      ofs_p1    <= '0;
      valido_p1 <= 1'b0;
    end else if (ld_conv) begin
      bin_p1    <= bin_c;
      ofs_p1    <= desp[2:0];
      valido_p1 <= valido_c;
    end
  end

  // Stage p2: time shadow and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CAMPOS; i++) campo[i] <= '0;
      dato_listo <= 1'b0;
      error_bcd  <= 1'b0;
      sobrecarga <= 1'b0;
    end else begin
      if (publicar && valido_p1) campo[ofs_p1] <= N'(bin_p1);
      dato_listo <= publicar && valido_p1;
      error_bcd  <= publicar && !valido_p1;
      sobrecarga <= sobre_d;
    end
  end

  assign segundos = campo[OFS_SEG];
  assign minutos  = campo[OFS_MIN];
  assign horas    = campo[OFS_HORA];
  assign fecha    = campo[OFS_FECHA];
  assign mes      = campo[OFS_MES];
  assign anio     = campo[OFS_ANIO];

endmodule
